// File: rtl/debounce_sync.sv
// Synchronizes a raw asynchronous level into clk and accepts a level change only
// after STABLE_CYCLES consecutive agreeing samples. Aborted qualifications pulse glitch.
module debounce_sync #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in,
    output logic out,
    output logic glitch
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("debounce_sync: SYNC_STAGES must be in 2..4");
    end
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("debounce_sync: STABLE_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        QUAL_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        QUAL_LOW    = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_in;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   glitch_q, glitch_d;

    // Plain flop chain: nothing may sit between stages or metastability can leak through.
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
                if (!reset_n) sync_q[gi] <= 1'b0;
                else          sync_q[gi] <= in;
            end
        end else begin : g_rest
            always_ff @(posedge clk) begin
                if (!reset_n) sync_q[gi] <= 1'b0;
                else          sync_q[gi] <= sync_q[gi-1];
            end
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= STABLE_LOW;
            cnt_q    <= '0;
            out_q    <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            glitch_q <= glitch_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        glitch_d = 1'b0;
        case (state_q)
            STABLE_LOW: begin
                out_d = 1'b0;
                if (sync_in) begin
                    state_d = QUAL_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            QUAL_HIGH: begin
                out_d = 1'b0;
                if (!sync_in) begin
                    state_d  = STABLE_LOW;
                    cnt_d    = '0;
                    glitch_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                    out_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                out_d = 1'b1;
                if (!sync_in) begin
                    state_d = QUAL_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            QUAL_LOW: begin
                out_d = 1'b1;
                if (sync_in) begin
                    state_d  = STABLE_HIGH;
                    cnt_d    = '0;
                    glitch_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LOW;
                    out_d   = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
                out_d   = 1'b0;
            end
        endcase
    end

    assign out    = out_q;
    assign glitch = glitch_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync with default parameters: each scheduled input
// cycle has a matching expected {out, glitch} entry checked just after its clock edge.
module tb_debounce_sync;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic in = 1'b0;
    logic out;
    logic glitch;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    typedef struct packed {
        logic rst_n;
        logic lvl;
    } stim_t;

    stim_t       stim_q[$];
    logic [1:0]  exp_q[$];

    debounce_sync #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(16)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .in     (in),
        .out    (out),
        .glitch (glitch)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic add_stim(input logic rst_n, input logic lvl, input int n);
        stim_t s;
        s.rst_n = rst_n;
        s.lvl   = lvl;
        for (int i = 0; i < n; i++) stim_q.push_back(s);
    endtask

    task automatic add_exp(input logic o, input logic g, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({o, g});
    endtask

    // Each entry is applied before an edge; its expectation is checked 1 ns after it.
    task automatic run_scenario(input string name);
        stim_t      s;
        logic [1:0] e;
        $display("scenario %s: %0d cycles", name, stim_q.size());
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            reset_n = s.rst_n;
            in      = s.lvl;
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() == 0) begin
                check_eq("exp_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq({name, ".out"}, {31'd0, out}, {31'd0, e[1]});
                check_eq({name, ".glitch"}, {31'd0, glitch}, {31'd0, e[0]});
            end
        end
        check_eq({name, ".leftover"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        // Reset with in high, then clean rise: out rises 18 edges after release.
        add_stim(1'b0, 1'b1, 3);   add_exp(1'b0, 1'b0, 3);
        add_stim(1'b1, 1'b1, 24);  add_exp(1'b0, 1'b0, 17); add_exp(1'b1, 1'b0, 7);
        run_scenario("reset_rise");

        // Clean fall from stable high.
        add_stim(1'b1, 1'b0, 24);  add_exp(1'b1, 1'b0, 17); add_exp(1'b0, 1'b0, 7);
        run_scenario("clean_fall");

        // 15 synchronized samples: rejected, one glitch pulse after edge 18.
        add_stim(1'b1, 1'b1, 15);  add_stim(1'b1, 1'b0, 10);
        add_exp(1'b0, 1'b0, 17);   add_exp(1'b0, 1'b1, 1);  add_exp(1'b0, 1'b0, 7);
        run_scenario("short_glitch");

        // 16 samples: accepted at edge 18, falls at edge 34 (16 cycles high).
        add_stim(1'b1, 1'b1, 16);  add_stim(1'b1, 1'b0, 40);
        add_exp(1'b0, 1'b0, 17);   add_exp(1'b1, 1'b0, 16); add_exp(1'b0, 1'b0, 23);
        run_scenario("boundary_accept");

        // Bounce 1,0,1,0 in 3-cycle segments then steady 1: aborts at edges 6 and 12,
        // steady 1 first sampled at edge 15 so out rises at edge 30.
        add_stim(1'b1, 1'b1, 3);   add_stim(1'b1, 1'b0, 3);
        add_stim(1'b1, 1'b1, 3);   add_stim(1'b1, 1'b0, 3);
        add_stim(1'b1, 1'b1, 22);
        add_exp(1'b0, 1'b0, 5);    add_exp(1'b0, 1'b1, 1);
        add_exp(1'b0, 1'b0, 5);    add_exp(1'b0, 1'b1, 1);
        add_exp(1'b0, 1'b0, 17);   add_exp(1'b1, 1'b0, 5);
        run_scenario("bounce_train");

        // Falling qualification reaches cnt=10 at edge 12; reset at edge 13 forces out=0
        // with no glitch; in stays high so a fresh 18-edge qualification follows release.
        add_stim(1'b1, 1'b0, 12);  add_exp(1'b1, 1'b0, 12);
        add_stim(1'b0, 1'b1, 3);   add_exp(1'b0, 1'b0, 3);
        add_stim(1'b1, 1'b1, 22);  add_exp(1'b0, 1'b0, 17); add_exp(1'b1, 1'b0, 5);
        run_scenario("reset_mid_qual");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/debounce_sync.md
# debounce_sync

Input conditioning stage that feeds the dual-edge detector. It takes a raw, asynchronous, possibly bouncing level (push-button, external strobe) and synchronizes it into the `clk` domain. It then qualifies each level change over a programmable number of consecutive cycles and presents a clean, registered level on `out`, which connects directly to the detector's `in`. Aborted qualifications are reported as a one-cycle `glitch` pulse for diagnostics.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops; legal range 2..4; any other value is an elaboration error.
- `STABLE_CYCLES`, default 16: consecutive synchronized samples required to accept a level change; must be ≥ 2; any other value is an elaboration error.
- `clk`  input  1  single clock; every flop in the block is rising-edge triggered.
- `reset_n`  input  1  reset, synchronous and active-low; takes effect on the `clk` edge where it is sampled low.
- `in`  input  1  raw asynchronous level; no timing relationship to `clk`.
- `out`  output  1  debounced level, registered.
- `glitch`  output  1  one-cycle pulse, registered; asserted when a qualification is aborted.

## Operation
- Synchronizer: a chain of `SYNC_STAGES` flops. `s[0]` samples `in`. `sync_in` is the last stage. No logic sits between the stages.
- Counter: `cnt`, width `$clog2(STABLE_CYCLES+1)`. It saturates by construction and never wraps.
- FSM states: STABLE_LOW, QUAL_HIGH, STABLE_HIGH, QUAL_LOW.
- STABLE_LOW:
  - `sync_in`=1: go to QUAL_HIGH, `cnt`<=1.
  - Otherwise: stay, `cnt`<=0.
- QUAL_HIGH:
  - `sync_in`=0: go to STABLE_LOW, `cnt`<=0, `glitch`<=1.
  - Else if `cnt`==STABLE_CYCLES-1: go to STABLE_HIGH, `out`<=1, `cnt`<=0.
  - Else: `cnt`<=`cnt`+1.
- STABLE_HIGH and QUAL_LOW mirror STABLE_LOW and QUAL_HIGH with polarity inverted. Acceptance drives `out`<=0.
- `out` changes only on an accepted transition. It is 0 in STABLE_LOW and QUAL_HIGH, and 1 in STABLE_HIGH and QUAL_LOW.
- `glitch` is 0 on every cycle except the one following an abort.
- Unreachable state encodings recover to STABLE_LOW with `out`=0 and `cnt`=0 on the next edge.

## Timing
- Reset values: all sync flops 0, state STABLE_LOW, `cnt`=0, `out`=0, `glitch`=0.
- Acceptance latency:
  - Edge numbering: the edge at which `s[0]` first captures the new level is edge 1.
  - `sync_in` changes after edge SYNC_STAGES.
  - `out` changes after edge SYNC_STAGES+STABLE_CYCLES, provided `sync_in` held the new level for all STABLE_CYCLES FSM samples.
  - With defaults this is 18 cycles.
- Rejection boundaries:
  - A pulse yielding exactly STABLE_CYCLES-1 synchronized samples is rejected: `glitch` pulses, `out` is unchanged.
  - A pulse yielding exactly STABLE_CYCLES samples is accepted.
- Abort timing: `glitch` asserts after the edge at which the FSM samples the reverting `sync_in`, and lasts exactly one cycle.
- Bounce trains: each reversion during qualification restarts counting from 1 on the next differing sample. Multiple aborts give one `glitch` pulse each; back-to-back aborts may give `glitch` high on consecutive cycles.
- Minimum `out` pulse width: STABLE_CYCLES cycles, because the opposite transition needs its own full qualification.
- Reset mid-qualification: reset wins. The next state is STABLE_LOW with `out`=0, no `glitch` pulse, and sync flops cleared. If `in` is high at release, a fresh qualification starts.
- Downstream guarantee: `out` is free of metastability and carries no transitions closer than STABLE_CYCLES cycles apart, so the edge detector sees at most one edge per STABLE_CYCLES cycles.

## Test plan
- Reset check:
  - Stimulus: hold `reset_n`=0 for 3 cycles with `in`=1, then release.
  - Response: `out`=0 and `glitch`=0 during reset; `out` rises after exactly 18 edges from release (defaults).
- Clean rising step:
  - Stimulus: `in` 0→1 and held.
  - Response: `out`=1 after 18 edges; `glitch` never asserts.
- Short glitch:
  - Stimulus: `in` high long enough to yield 15 synchronized samples (STABLE_CYCLES=16).
  - Response: `out` stays 0; exactly one `glitch` pulse one cycle wide.
- Boundary accept:
  - Stimulus: high pulse yielding exactly 16 samples, then low.
  - Response: `out` high for 16 cycles minimum, then falls 16 cycles after `sync_in` falls.
- Bounce train:
  - Stimulus: 1,0,1,0 with 3-cycle segments, then steady 1.
  - Response: two `glitch` pulses; `out` rises 16 cycles after the final steady 1 reaches `sync_in`.
- Reset mid-qualification:
  - Stimulus: assert `reset_n`=0 while in QUAL_LOW with `cnt`=10.
  - Response: `out`=0 next edge, no `glitch`; after release with `in`=1, `out` rises after 18 edges.
